// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: FETCH -> WAIT -> HOLD, with redirect/kill handling.
// Optional statistics counters are built when the FETCH_STATS_EN macro is defined.
`timescale 1ns/1ps

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_redirects,
  output logic [31:0] stat_drops,
`endif
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and payload is stable while valid waits.

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        kill;

  logic        req_fire;
  logic        rsp_take;
  logic        rsp_drop;
  logic        rsp_keep;
  logic [31:0] redirect_pc;

  assign req_fire    = (state == S_FETCH) && imem_req_ready;
  assign rsp_take    = (state == S_WAIT) && imem_rsp_valid;
  // A response is wrong-path if it was already killed or a redirect lands with it.
  assign rsp_drop    = rsp_take && (kill || redirect);
  assign rsp_keep    = rsp_take && !kill && !redirect;
  assign redirect_pc = redirect_target & ~32'h0000_0003;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH: begin
        if (req_fire) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_drop)      state_next = S_FETCH;
        else if (rsp_keep) state_next = S_HOLD;
      end
      S_HOLD: begin
        if (redirect || dec_ready) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req_valid = 1'b0;
    dec_valid      = 1'b0;
    imem_addr      = pc;
    dbg_state      = state;
    unique case (state)
      S_FETCH: imem_req_valid = 1'b1;
      S_WAIT:  imem_req_valid = 1'b0;
      S_HOLD:  dec_valid      = 1'b1;
      default: begin
        imem_req_valid = 1'b0;
        dec_valid      = 1'b0;
      end
    endcase
  end

  // Program counter: redirect always wins over sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (rsp_keep) begin
      pc <= req_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc <= 32'h0;
    end else if (req_fire) begin
      req_pc <= pc;
    end
  end

  // Kill marks the single outstanding request as wrong-path until its response drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill <= 1'b0;
    end else if (rsp_drop) begin
      kill <= 1'b0;
    end else if (req_fire && redirect) begin
      kill <= 1'b1;
    end else if ((state == S_WAIT) && redirect) begin
      kill <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_instr <= 32'h0;
      dec_pc    <= 32'h0;
    end else if (rsp_keep) begin
      dec_instr <= imem_rsp_data;
      dec_pc    <= req_pc;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_redirects <= 32'h0;
      stat_drops     <= 32'h0;
    end else begin
      if (redirect) stat_redirects <= stat_redirects + 32'd1;
      if (rsp_drop) stat_drops     <= stat_drops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory and decode are driven from one sequence,
// decoded {pc, instr} pairs are scoreboarded against an expected queue.
`timescale 1ns/1ps

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [1:0]  S_FETCH  = 2'd0;
  localparam logic [1:0]  S_WAIT   = 2'd1;
  localparam logic [1:0]  S_HOLD   = 2'd2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [1:0]  dbg_state;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_redirects;
  logic [31:0] stat_drops;
`endif

  int checks;
  int failures;
  int exp_redirects;
  int exp_drops;
  logic [63:0] exp_q[$];

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
`ifdef FETCH_STATS_EN
    .stat_redirects  (stat_redirects),
    .stat_drops      (stat_drops),
`endif
    .dbg_state       (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef FETCH_STATS_EN
    check({tag, "_redirects"}, {32'h0, stat_redirects}, 64'(exp_redirects));
    check({tag, "_drops"}, {32'h0, stat_drops}, 64'(exp_drops));
`else
    if (tag.len() == 0) $display("stats disabled");
`endif
  endtask

  // Pop the scoreboard for the instruction currently presented to decode.
  task automatic check_decode(input string tag);
    logic [63:0] exp;
    check({tag, "_dec_valid"}, {63'h0, dec_valid}, 64'h1);
    checks++;
    assert (exp_q.size() > 0) else begin
      failures++;
      $error("FAIL %s_queue observed=decode expected=empty", tag);
    end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_pc_instr"}, {dec_pc, dec_instr}, exp);
    end
  endtask

  task automatic check_fetch_idle(input string tag, input logic [31:0] addr);
    check({tag, "_state"}, {62'h0, dbg_state}, {62'h0, S_FETCH});
    check({tag, "_req_valid"}, {63'h0, imem_req_valid}, 64'h1);
    check({tag, "_addr"}, {32'h0, imem_addr}, {32'h0, addr});
    check({tag, "_dec_valid"}, {63'h0, dec_valid}, 64'h0);
  endtask

  // Driver: issue a request at addr, answer one cycle later, stop in HOLD.
  task automatic fetch_to_hold(input string tag, input logic [31:0] addr);
    logic [31:0] data;
    data = $urandom();
    check_fetch_idle({tag, "_f"}, addr);
    imem_req_ready = 1'b1;
    exp_q.push_back({addr, data});
    @(negedge clk);
    imem_req_ready = 1'b0;
    check({tag, "_w_state"}, {62'h0, dbg_state}, {62'h0, S_WAIT});
    check({tag, "_w_req_valid"}, {63'h0, imem_req_valid}, 64'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom();
    check({tag, "_h_state"}, {62'h0, dbg_state}, {62'h0, S_HOLD});
    check_decode(tag);
  endtask

  task automatic consume(input string tag);
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    check({tag, "_c_dec_valid"}, {63'h0, dec_valid}, 64'h0);
    check({tag, "_c_state"}, {62'h0, dbg_state}, {62'h0, S_FETCH});
  endtask

  task automatic fetch_one(input string tag, input logic [31:0] addr);
    fetch_to_hold(tag, addr);
    consume(tag);
  endtask

  task automatic drive_redirect(input logic [31:0] target);
    redirect        = 1'b1;
    redirect_target = target;
    exp_redirects++;
  endtask

  initial begin
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    checks          = 0;
    failures        = 0;
    exp_redirects   = 0;
    exp_drops       = 0;
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    dec_ready       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_fetch_idle("reset", RESET_PC);
    check("reset_dec_pc", {32'h0, dec_pc}, 64'h0);
    check("reset_dec_instr", {32'h0, dec_instr}, 64'h0);
    check_stats("reset");
    rst = 1'b0;

    // Sequential stream, one instruction every three cycles
    fetch_one("seq0", 32'h0000_0000);
    fetch_one("seq1", 32'h0000_0004);
    fetch_one("seq2", 32'h0000_0008);

    // Decode stall in HOLD; stray responses must not disturb the held word
    fetch_to_hold("stall", 32'h0000_000C);
    held_pc    = dec_pc;
    held_instr = dec_instr;
    for (int i = 0; i < 5; i++) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom();
      @(negedge clk);
      check("stall_dec_valid", {63'h0, dec_valid}, 64'h1);
      check("stall_pc_instr", {dec_pc, dec_instr}, {held_pc, held_instr});
      check("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
    end
    imem_rsp_valid = 1'b0;
    consume("stall");

    // Memory back-pressure: request held; stray responses in FETCH ignored
    for (int i = 0; i < 4; i++) begin
      check_fetch_idle("bp", 32'h0000_0010);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom();
      @(negedge clk);
    end
    imem_rsp_valid = 1'b0;

    // Redirect coincident with acceptance: response for 0x10 must be dropped
    check_fetch_idle("acc_redir", 32'h0000_0010);
    imem_req_ready = 1'b1;
    drive_redirect(32'h0000_0040);
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect       = 1'b0;
    check("acc_redir_state", {62'h0, dbg_state}, {62'h0, S_WAIT});
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    exp_drops++;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check_stats("acc_redir");
    fetch_one("after_acc_redir", 32'h0000_0040);

    // Redirect in WAIT, response the following cycle
    check_fetch_idle("wait_redir", 32'h0000_0044);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    drive_redirect(32'h0000_0102);
    @(negedge clk);
    redirect = 1'b0;
    check("wait_redir_state", {62'h0, dbg_state}, {62'h0, S_WAIT});
    check("wait_redir_req_valid", {63'h0, imem_req_valid}, 64'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    exp_drops++;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check_fetch_idle("wait_redir_after", 32'h0000_0100);
    check_stats("wait_redir");

    // Redirect and response in the same WAIT cycle
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    drive_redirect(32'h0000_0200);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = $urandom();
    exp_drops++;
    @(negedge clk);
    redirect       = 1'b0;
    imem_rsp_valid = 1'b0;
    check_fetch_idle("same_cycle", 32'h0000_0200);
    check_stats("same_cycle");

    // Redirect in HOLD, with and without dec_ready
    fetch_to_hold("hold_rdy", 32'h0000_0200);
    drive_redirect(32'h0000_0300);
    dec_ready = 1'b1;
    @(negedge clk);
    redirect  = 1'b0;
    dec_ready = 1'b0;
    check_fetch_idle("hold_rdy_after", 32'h0000_0300);
    fetch_to_hold("hold_nrdy", 32'h0000_0300);
    drive_redirect(32'h0000_0380);
    @(negedge clk);
    redirect = 1'b0;
    check_fetch_idle("hold_nrdy_after", 32'h0000_0380);

    // Redirect in FETCH without handshake; low target bits are cleared
    drive_redirect(32'h0000_03FF);
    @(negedge clk);
    check_fetch_idle("fetch_redir", 32'h0000_03FC);
    drive_redirect(32'hFFFF_FFFE);
    @(negedge clk);
    redirect = 1'b0;
    check_fetch_idle("fetch_redir2", 32'hFFFF_FFFC);
    check_stats("fetch_redir");

    // PC wraps modulo 2^32
    fetch_one("wrap", 32'hFFFF_FFFC);
    check_fetch_idle("wrap_after", 32'h0000_0000);

    // Reset in WAIT; the late response must be ignored
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("rst_wait_state", {62'h0, dbg_state}, {62'h0, S_WAIT});
    rst           = 1'b1;
    exp_redirects = 0;
    exp_drops     = 0;
    #1;
    check_fetch_idle("rst_async", RESET_PC);
    check("rst_async_dec_pc", {32'h0, dec_pc}, 64'h0);
    check("rst_async_dec_instr", {32'h0, dec_instr}, 64'h0);
    check_stats("rst_async");
    @(negedge clk);
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check_fetch_idle("rst_late_rsp", RESET_PC);
    fetch_one("post_rst", RESET_PC);
    check_stats("final");

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL leftover_expected observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
